vga_pattern_gen: RTL

- Parametrised successor to the fixed 8-bar colour test pattern.
- Sits between the hvsync timing generator (25 MHz pixel domain) and the VGA pins.
- Takes hpos/vpos/display_on/syncs and produces one of four selectable patterns: bars, checkerboard, gradient, grid.
- Optional per-frame scrolling; pipelined, with syncs delayed to stay aligned with RGB.

---
 rtl/vga_pkg.sv | 31 +++
 rtl/vga_delay_line.sv | 45 ++++
 rtl/vga_pattern_gen.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Brief    : Shared encodings and constants for the VGA pattern generator.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

  // Pattern selector encodings as presented on the mode input
  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_GRAD  = 2'd2,
    MODE_GRID  = 2'd3
  } mode_e;

  // 640x480 visible area of the standard 25 MHz VGA timing
  localparam int H_ACTIVE_640 = 640;
  localparam int V_ACTIVE_480 = 480;

  // Colour masks, one bit per channel in {r, g, b} order
  localparam logic [2:0] WHITE = 3'b111;
  localparam logic [2:0] BLACK = 3'b000;

  // Bar colour mask: bar index 0 is white, the last bar is black
  function automatic logic [2:0] bar_colour(input logic [2:0] eff3);
    return ~eff3;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : vga_delay_line
// Brief    : Width/depth parametrised shift register with a configurable
//            reset value, used to keep syncs aligned with the colour pipe.
// Revision : 1.0 - initial release
// ============================================================================
module vga_delay_line
  import vga_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q;
  logic [DEPTH-1:0][WIDTH-1:0] stage_d;

  // Shift one position per clock, new sample enters at index 0
  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = d;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Stage registers; every tap returns to the idle value on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= {DEPTH{RST_VAL}};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/vga_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_pattern_gen
// Brief    : Selectable VGA test pattern source (bars, checker, gradient,
//            grid) with optional bar scrolling. Two-stage pipeline; syncs
//            are delayed to stay aligned with the colour outputs.
// Revision : 1.0 - initial release
// ============================================================================
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_640,
  parameter int V_ACTIVE   = V_ACTIVE_480,
  parameter int COLOR_W    = 4,
  parameter int BAR_COUNT  = 8,
  parameter int CHECK_LOG2 = 5,
  parameter int GRID_LOG2  = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [9:0]         hpos,
  input  logic [9:0]         vpos,
  input  logic               display_on,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic [1:0]         mode,
  input  logic               scroll_en,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic [COLOR_W-1:0] vga_r,
  output logic [COLOR_W-1:0] vga_g,
  output logic [COLOR_W-1:0] vga_b,
  output logic [7:0]         frame_cnt
);

  localparam int         c_bar_w     = $clog2(BAR_COUNT);
  localparam int         c_bar_shift = 3 - c_bar_w;
  localparam int         c_bar_px    = H_ACTIVE / BAR_COUNT;
  localparam int         c_v_msb     = $clog2(V_ACTIVE) - 1;
  localparam logic [9:0] c_h_act     = 10'(H_ACTIVE);
  localparam logic [9:0] c_v_act     = 10'(V_ACTIVE);
  localparam logic [9:0] c_h_last    = 10'(H_ACTIVE - 1);
  localparam logic [9:0] c_v_last    = 10'(V_ACTIVE - 1);
  localparam logic [9:0] c_bar_last  = 10'(c_bar_px - 1);
  localparam logic [c_bar_w-1:0] c_bar_one = 1;

  // Frame-level state
  logic [7:0]         frame_cnt_q, frame_cnt_d;
  mode_e              mode_q, mode_d;
  logic               frame_boundary;

  // Column counter (stage-1 aligned)
  logic [9:0]         col_cnt_q, col_cnt_d;
  logic [c_bar_w-1:0] bar_idx_q, bar_idx_d;
  logic               col_valid_q, col_valid_d;

  // Stage-1 pixel attributes
  logic               oob_s1_q, oob_s1_d;
  logic               check_s1_q, check_s1_d;
  logic               grid_s1_q, grid_s1_d;
  logic               scroll_s1_q, scroll_s1_d;
  logic [COLOR_W-1:0] grad_r_s1_q, grad_r_s1_d;
  logic [COLOR_W-1:0] grad_g_s1_q, grad_g_s1_d;
  logic               de_s1;

  // Stage-2 colour
  logic [COLOR_W-1:0] r_q, r_d;
  logic [COLOR_W-1:0] g_q, g_d;
  logic [COLOR_W-1:0] b_q, b_d;
  logic [c_bar_w-1:0] bar_eff;
  logic [2:0]         bar_eff3;
  logic [2:0]         mask;
  logic [1:0]         sync_out;

  // Frame counter and pattern latch only move at the frame boundary so the
  // pattern never changes part way down the screen
  always_comb begin
    frame_boundary = (hpos == 10'd0) && (vpos == c_v_act);
    frame_cnt_d    = frame_cnt_q;
    mode_d         = mode_q;
    if (frame_boundary) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
      mode_d      = mode_e'(mode);
    end
  end

  // Frame-level registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt_q <= 8'd0;
      mode_q      <= MODE_BARS;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      mode_q      <= mode_d;
    end
  end

  // Bar column tracking by counting pixels instead of dividing hpos;
  // col_valid stays low after reset until a line start resynchronises it
  always_comb begin
    col_cnt_d   = col_cnt_q + 10'd1;
    bar_idx_d   = bar_idx_q;
    col_valid_d = col_valid_q;
    if (hpos == 10'd0) begin
      col_cnt_d   = 10'd0;
      bar_idx_d   = '0;
      col_valid_d = 1'b1;
    end else if (col_cnt_q == c_bar_last) begin
      col_cnt_d = 10'd0;
      bar_idx_d = bar_idx_q + c_bar_one;
    end
  end

  // Column counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_cnt_q   <= 10'd0;
      bar_idx_q   <= '0;
      col_valid_q <= 1'b0;
    end else begin
      col_cnt_q   <= col_cnt_d;
      bar_idx_q   <= bar_idx_d;
      col_valid_q <= col_valid_d;
    end
  end

  // Stage 1: derive per-pixel pattern flags straight from the position
  always_comb begin
    oob_s1_d    = (hpos >= c_h_act) || (vpos >= c_v_act);
    check_s1_d  = hpos[CHECK_LOG2] ^ vpos[CHECK_LOG2];
    grid_s1_d   = (hpos == 10'd0) || (hpos == c_h_last) ||
                  (vpos == 10'd0) || (vpos == c_v_last) ||
                  (hpos[GRID_LOG2-1:0] == '0) ||
                  (vpos[GRID_LOG2-1:0] == '0);
    scroll_s1_d = scroll_en;
    grad_r_s1_d = hpos[9 -: COLOR_W];
    // Top bit chosen so the last visible line lands near full scale
    grad_g_s1_d = vpos[c_v_msb -: COLOR_W];
  end

  // Stage-1 registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      oob_s1_q    <= 1'b0;
      check_s1_q  <= 1'b0;
      grid_s1_q   <= 1'b0;
      scroll_s1_q <= 1'b0;
      grad_r_s1_q <= '0;
      grad_g_s1_q <= '0;
    end else begin
      oob_s1_q    <= oob_s1_d;
      check_s1_q  <= check_s1_d;
      grid_s1_q   <= grid_s1_d;
      scroll_s1_q <= scroll_s1_d;
      grad_r_s1_q <= grad_r_s1_d;
      grad_g_s1_q <= grad_g_s1_d;
    end
  end

  // Stage 2: pick the colour for the active pattern and apply blanking.
  // mode_q and frame_cnt_q only change during vertical blanking, so using
  // them here directly cannot shear a visible pixel.
  always_comb begin
    bar_eff  = bar_idx_q + (scroll_s1_q ? frame_cnt_q[3 +: c_bar_w] : '0);
    // Fewer than 8 bars use the index as the MSBs of the 3-bit colour
    bar_eff3 = 3'(bar_eff) << c_bar_shift;
    mask     = BLACK;
    case (mode_q)
      MODE_BARS:  mask = bar_colour(bar_eff3);
      MODE_CHECK: mask = check_s1_q ? WHITE : BLACK;
      MODE_GRID:  mask = grid_s1_q ? WHITE : BLACK;
      default:    mask = BLACK;
    endcase
    r_d = {COLOR_W{mask[2]}};
    g_d = {COLOR_W{mask[1]}};
    b_d = {COLOR_W{mask[0]}};
    if (mode_q == MODE_GRAD) begin
      r_d = grad_r_s1_q;
      g_d = grad_g_s1_q;
      b_d = frame_cnt_q[7 -: COLOR_W];
    end
    if (!de_s1 || oob_s1_q || !col_valid_q) begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
    end
  end

  // Stage-2 colour registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
    end else begin
      r_q <= r_d;
      g_q <= g_d;
      b_q <= b_d;
    end
  end

  // Syncs idle high through reset and match the two-stage colour latency
  vga_delay_line #(
    .WIDTH   (2),
    .DEPTH   (2),
    .RST_VAL (2'b11)
  ) u_sync_dly (
    .clk   (clk),
    .rst_n (reset),
    .d     ({hsync_in, vsync_in}),
    .q     (sync_out)
  );

  // display_on aligned with stage 1; stage 2 uses it to blank
  vga_delay_line #(
    .WIDTH   (1),
    .DEPTH   (1),
    .RST_VAL (1'b0)
  ) u_de_dly (
    .clk   (clk),
    .rst_n (reset),
    .d     (display_on),
    .q     (de_s1)
  );

  assign hsync_out = sync_out[1];
  assign vsync_out = sync_out[0];
  assign vga_r     = r_q;
  assign vga_g     = g_q;
  assign vga_b     = b_q;
  assign frame_cnt = frame_cnt_q;

endmodule
`default_nettype wire
